// File: rtl/dma_pkg.sv
// Shared types and constants for the DRAM <-> stream sequencer.
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_e;

  localparam logic DIR_READ    = 1'b0;
  localparam logic DIR_WRITE   = 1'b1;
  localparam int   WORD_STRIDE = 4;

endpackage

// File: rtl/dram_dma_if.sv
// Command, DRAM port and both streams of dram_dma; master is the sequencer side.
interface dram_dma_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
);
  logic                  start;
  logic                  dir;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  len;
  logic                  busy;
  logic                  done;
  logic                  dram_we;
  logic [ADDR_WIDTH-1:0] dram_addr;
  logic [DATA_WIDTH-1:0] dram_din;
  logic [DATA_WIDTH-1:0] dram_dout;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;

  modport master (
    input  start, dir, base_addr, len, dram_dout, m_ready, s_valid, s_data,
    output busy, done, dram_we, dram_addr, dram_din, m_valid, m_data, s_ready
  );

  modport slave (
    output start, dir, base_addr, len, dram_dout, m_ready, s_valid, s_data,
    input  busy, done, dram_we, dram_addr, dram_din, m_valid, m_data, s_ready
  );
endinterface

// File: rtl/dma_fifo.sv
// Show-ahead FIFO for DRAM read returns; head reads as zero when empty.
module dma_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/dram_dma.sv
// Moves len words between DRAM and the valid/ready streams; reads are credit-limited
// so every in-flight DRAM return always has a FIFO slot waiting for it.
//
// state    | meaning
// ST_IDLE  | waiting for start, command fields latched on acceptance
// ST_READ  | issuing DRAM reads, draining FIFO onto m_* stream
// ST_WRITE | accepting s_* words, each presented as a DRAM write next cycle
// ST_DONE  | one-cycle completion pulse, back to idle
module dram_dma
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  dram_dma_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDIT = (CW+1)'(FIFO_DEPTH);

  dma_state_e state_q, state_d;

  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued_q;
  logic [LEN_WIDTH-1:0]  delivered_q;
  logic [LEN_WIDTH-1:0]  accepted_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  pend_q;
  logic                  we_q;
  logic                  busy_q;
  logic                  done_q;

  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CW:0]           occupancy;

  logic accept, issue, m_valid, pop, s_ready, s_fire, rd_last, wr_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.len == '0)             state_d = ST_DONE;
          else if (bus.dir == DIR_WRITE) state_d = ST_WRITE;
          else                           state_d = ST_READ;
        end
      end
      ST_READ:  if (rd_last) state_d = ST_DONE;
      ST_WRITE: if (wr_last) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, pend_q};

  always_comb begin
    accept  = (state_q == ST_IDLE) && bus.start;
    issue   = (state_q == ST_READ) && (issued_q < len_q) && (occupancy < CREDIT);
    m_valid = (fifo_count != '0);
    pop     = m_valid && bus.m_ready;
    s_ready = (state_q == ST_WRITE) && (accepted_q < len_q);
    s_fire  = s_ready && bus.s_valid;
    // finish on the handshake that delivers the last word, not a cycle later
    rd_last = pop && (delivered_q == len_q - LEN_WIDTH'(1));
    wr_last = we_q && (accepted_q == len_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      accepted_q  <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      pend_q      <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      busy_q <= (state_d != ST_IDLE);
      done_q <= (state_d == ST_DONE);
      pend_q <= issue;
      we_q   <= s_fire;
      if (accept) begin
        len_q       <= bus.len;
        issued_q    <= '0;
        delivered_q <= '0;
        accepted_q  <= '0;
        addr_q      <= bus.base_addr;
      end
      if (issue) begin
        issued_q <= issued_q + LEN_WIDTH'(1);
        addr_q   <= addr_q + ADDR_WIDTH'(WORD_STRIDE);
      end
      if (pop) delivered_q <= delivered_q + LEN_WIDTH'(1);
      // the first write goes to base itself, later ones step from the previous one
      if (s_fire) begin
        accepted_q <= accepted_q + LEN_WIDTH'(1);
        din_q      <= bus.s_data;
        if (accepted_q != '0) addr_q <= addr_q + ADDR_WIDTH'(WORD_STRIDE);
      end
    end
  end

  dma_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pend_q),
    .din   (bus.dram_dout),
    .pop   (pop),
    .dout  (fifo_head),
    .count (fifo_count)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dram_we   = we_q;
  assign bus.dram_addr = addr_q;
  assign bus.dram_din  = din_q;
  assign bus.m_valid   = m_valid;
  assign bus.m_data    = fifo_head;
  assign bus.s_ready   = s_ready;

endmodule

// File: tb/tb_dram_dma.sv
// Directed bench for dram_dma: word-level memory model plus expected-transfer queues.
module tb_dram_dma;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_dma_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus();

  dram_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // background DRAM contents: a few preloaded words, otherwise a tag of the word index
  function automatic logic [31:0] bg(input int idx);
    logic [17:0] w;
    w = idx[17:0];
    case (w)
      18'h40:  return 32'h11;
      18'h41:  return 32'h22;
      18'h42:  return 32'h33;
      18'h43:  return 32'h44;
      default: return {14'h3A5, w};
    endcase
  endfunction

  logic [31:0] dram_mem [int];
  logic [31:0] ref_mem  [int];

  always @(posedge clk) begin
    int wi;
    wi = int'(bus.dram_addr[19:2]);
    bus.dram_dout <= dram_mem.exists(wi) ? dram_mem[wi] : bg(wi);
    if (bus.dram_we) dram_mem[wi] = bus.dram_din;
  end

  function automatic logic [31:0] ref_rd(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : bg(idx);
  endfunction

  logic [31:0] exp_rd [$];
  logic [31:0] got_rd [$];
  logic [51:0] exp_wr [$];
  logic [31:0] wvec   [$];

  int first_mv, first_we, last_we, we_cnt, done_cyc, wr_left, t0_g;
  bit s_fire;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [51:0] e;
    if (rst) begin
      s_fire = bus.s_valid && bus.s_ready;
      if (bus.m_valid && first_mv < 0) first_mv = cyc;
      if (exp_rd.size() == 0) check("m_valid_idle", bus.m_valid, 0);
      else if (bus.m_valid && bus.m_ready) begin
        got_rd.push_back(bus.m_data);
        check("m_data", bus.m_data, exp_rd.pop_front());
      end
      if (exp_wr.size() == 0) check("we_idle", bus.dram_we, 0);
      else if (bus.dram_we) begin
        e = exp_wr.pop_front();
        check("dram_addr", bus.dram_addr, e[51:32]);
        check("dram_din", bus.dram_din, e[31:0]);
        we_cnt++;
        if (first_we < 0) first_we = cyc;
        last_we = cyc;
      end
      if (wr_left == 0) check("s_ready_idle", bus.s_ready, 0);
      if (bus.done && done_cyc < 0) done_cyc = cyc;
    end
  end

  task automatic run_cmd(input string name, input bit d, input logic [19:0] base, input int n,
                         input bit tog, input int inj, input int exp_done);
    int rel;
    int widx;
    logic [19:0] a;
    widx = 0;
    for (int i = 0; i < n; i++) begin
      a = base + 20'(4 * i);
      if (!d) exp_rd.push_back(ref_rd(int'(a[19:2])));
      else begin
        exp_wr.push_back({a, wvec[i]});
        ref_mem[int'(a[19:2])] = wvec[i];
      end
    end
    got_rd.delete();
    first_mv = -1; first_we = -1; last_we = -1; we_cnt = 0; done_cyc = -1; s_fire = 0;
    @(posedge clk); #1;
    t0_g = cyc;
    bus.start = 1'b1; bus.dir = d; bus.base_addr = base; bus.len = 16'(n);
    bus.m_ready = 1'b1;
    wr_left = d ? n : 0;
    bus.s_valid = d && (n > 0);
    bus.s_data = (d && n > 0) ? wvec[0] : '0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      rel = cyc - t0_g;
      bus.start = (rel == inj);
      if (rel == inj) begin
        bus.dir = ~d; bus.len = 16'd5; bus.base_addr = 20'h0;
      end
      if (s_fire) begin widx++; s_fire = 0; end
      wr_left = d ? n - widx : 0;
      bus.s_valid = d && (widx < n);
      bus.s_data = (d && widx < n) ? wvec[widx] : '0;
      bus.m_ready = tog ? ~bus.m_ready : 1'b1;
      if (rel == 1) check({name, "_busy_on"}, bus.busy, 1);
      if (done_cyc >= 0) break;
    end
    check({name, "_done_seen"}, done_cyc >= 0, 1);
    if (exp_done >= 0) check({name, "_done_cycle"}, done_cyc - t0_g, exp_done);
    @(negedge clk);
    check({name, "_busy_off"}, bus.busy, 0);
    check({name, "_done_pulse"}, bus.done, 0);
    check({name, "_rd_left"}, exp_rd.size(), 0);
    check({name, "_wr_left"}, exp_wr.size(), 0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_done"}, bus.done, 0);
    check({name, "_we"}, bus.dram_we, 0);
    check({name, "_m_valid"}, bus.m_valid, 0);
    check({name, "_s_ready"}, bus.s_ready, 0);
    check({name, "_addr"}, bus.dram_addr, 0);
    check({name, "_din"}, bus.dram_din, 0);
    check({name, "_m_data"}, bus.m_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [19:0] a;
    bus.start = 0; bus.dir = 0; bus.base_addr = '0; bus.len = '0;
    bus.m_ready = 0; bus.s_valid = 0; bus.s_data = '0;
    wr_left = 0; done_cyc = -1; first_mv = -1; first_we = -1; last_we = -1; we_cnt = 0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1 rst = 1'b1;

    // READ 4 words with a stray WRITE start while busy
    run_cmd("rd4", 0, 20'h100, 4, 0, 2, 7);
    check("rd4_count", got_rd.size(), 4);
    check("rd4_w0", got_rd[0], 32'h11);
    check("rd4_w1", got_rd[1], 32'h22);
    check("rd4_w2", got_rd[2], 32'h33);
    check("rd4_w3", got_rd[3], 32'h44);
    check("rd4_first_valid", first_mv - t0_g, 3);

    // backpressure: ready 1,0,1,0 -> deliveries on even cycles 4..18
    run_cmd("rd8_tog", 0, 20'h400, 8, 1, -1, 19);
    check("rd8_count", got_rd.size(), 8);

    wvec.delete();
    wvec.push_back(32'hA); wvec.push_back(32'hB); wvec.push_back(32'hC);
    run_cmd("wr3", 1, 20'h20, 3, 0, -1, 5);
    check("wr3_first_we", first_we - t0_g, 2);
    check("wr3_last_we", last_we - t0_g, 4);
    check("wr3_we_count", we_cnt, 3);

    run_cmd("rdback", 0, 20'h20, 3, 0, -1, 6);
    check("rdback_w0", got_rd[0], 32'hA);
    check("rdback_w1", got_rd[1], 32'hB);
    check("rdback_w2", got_rd[2], 32'hC);

    run_cmd("rd0", 0, 20'h500, 0, 0, 1, 1);
    run_cmd("wr0", 1, 20'h500, 0, 0, 1, 1);

    run_cmd("wrap", 0, 20'hFFFF8, 4, 0, -1, 7);
    check("wrap_w0", got_rd[0], 32'h0E97FFFE);
    check("wrap_w1", got_rd[1], 32'h0E97FFFF);
    check("wrap_w2", got_rd[2], 32'h0E940000);
    check("wrap_w3", got_rd[3], 32'h0E940001);

    // reset while the FIFO holds two undelivered words
    for (int i = 0; i < 8; i++) begin
      a = 20'h300 + 20'(4 * i);
      exp_rd.push_back(ref_rd(int'(a[19:2])));
    end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dir = 1'b0; bus.base_addr = 20'h300; bus.len = 16'd8;
    bus.m_ready = 1'b0;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_m_valid", bus.m_valid, 1);
    #2 rst = 1'b0;
    #1 check_idle_outputs("mid_rst");
    exp_rd.delete();
    @(posedge clk); #1 rst = 1'b1;

    run_cmd("post_rst", 0, 20'h240, 2, 0, -1, 5);
    check("post_rst_w0", got_rd[0], 32'h0E940090);
    check("post_rst_w1", got_rd[1], 32'h0E940091);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_dma.md
# dram_dma

Sequencer between the byte-addressed word-wide DRAM model and the on-chip buffers. On a `start` command it moves `len` 32-bit words either from DRAM to an outbound valid/ready stream (READ) or from an inbound valid/ready stream into DRAM (WRITE). The DRAM presents registered read data one cycle after the address, so the block tracks in-flight reads and buffers them to honour stream backpressure.

## Interface
- `ADDR_WIDTH`, 20, DRAM byte-address width
- `DATA_WIDTH`, 32, word width (DRAM `din`/`dout` width)
- `LEN_WIDTH`, 16, transfer length field width (words)
- `FIFO_DEPTH`, 4, read-return buffer entries (power of two, ≥3)
- `clk`  in  1  clock. One clock; all logic on its rising edge.
- `rst`  in  1  reset. Asynchronous, active-low.
- `start`  in  1  command strobe, sampled only in IDLE
- `dir`  in  1  0 = READ (DRAM→stream), 1 = WRITE (stream→DRAM)
- `base_addr`  in  ADDR_WIDTH  first byte address
- `len`  in  LEN_WIDTH  word count
- `busy`  out  1  high from the cycle after start acceptance through the DONE cycle
- `done`  out  1  one-cycle completion pulse
- `dram_we`  out  1  DRAM write enable
- `dram_addr`  out  ADDR_WIDTH  DRAM byte address
- `dram_din`  out  DATA_WIDTH  DRAM write data
- `dram_dout`  in  DATA_WIDTH  DRAM read data (valid the cycle after address)
- `m_valid` / `m_ready` / `m_data`  out/in/out  1/1/DATA_WIDTH  read stream
- `s_valid` / `s_ready` / `s_data`  in/out/in  1/1/DATA_WIDTH  write stream

## Operation
- States: IDLE, READ, WRITE, DONE. IDLE→READ/WRITE on `start` per `dir` (len≠0); IDLE→DONE if len=0; READ/WRITE→DONE on completion; DONE→IDLE unconditionally.
- `start` outside IDLE is ignored; command fields latched on acceptance.
- Address register loads `base_addr`, advances +4 per issued word, wraps modulo 2^ADDR_WIDTH. `base_addr[1:0]` passed through unmodified.
- READ: issue when `issued < len` and `fifo_count + inflight < FIFO_DEPTH`; issue = present `dram_addr`, set 1-cycle pending flag; cycle after, capture `dram_dout` into FIFO. `m_valid` = FIFO non-empty, `m_data` = FIFO head. Complete when `delivered == len` (handshakes counted). `dram_we`=0 throughout.
- WRITE: `s_ready`=1 while `accepted < len`. Each handshake registers `dram_we`=1, `dram_addr`, `dram_din`=`s_data` for the following cycle; otherwise `dram_we`=0. Complete after the last write cycle has been presented.
- Counters LEN_WIDTH wide; no overflow possible since they stop at `len`.

## Timing
- Reset values: `busy`, `done`, `dram_we`, `m_valid`, `s_ready` = 0; `dram_addr`, `dram_din`, `m_data` = 0; FIFO empty; state IDLE. Reset mid-transfer discards all in-flight and buffered data.
- All outputs registered except `m_valid`/`m_data` (FIFO head) and `s_ready` (state decode).
- READ: `start` in cycle 0 → `dram_addr`=base in cycle 1 → FIFO write end of cycle 2 → `m_valid` in cycle 3. With `m_ready` held 1, one word per cycle sustained.
- WRITE: handshake in cycle k → `dram_we`=1 in cycle k+1, DRAM commits at end of k+1. Sustained one word/cycle.
- `done`=1 for exactly the DONE cycle; `busy` drops the following cycle; new `start` accepted that cycle.
- FIFO simultaneous push+pop when full-minus-one or empty: both take effect; occupancy unchanged.

## Structure
- Package `dma_pkg`: state enum `dma_state_e`, `DIR_READ`/`DIR_WRITE` constants, word-stride constant 4.
- Sub-module `dma_fifo`: synchronous show-ahead FIFO (DEPTH, WIDTH params), `count` output, same clock/reset.

## Test plan
- READ base=0x100 len=4, `m_ready`=1, DRAM preloaded 0x11..0x44 → `m_data` 0x11,0x22,0x33,0x44 in cycles 3–6, `done` in cycle 7, `dram_we` never 1.
- READ len=8 with `m_ready` toggling 1,0,1,0 → all 8 words in order, no duplicates, `fifo_count+inflight` never exceeds 4.
- WRITE base=0x20 len=3, `s_data` 0xA,0xB,0xC back-to-back → `dram_we` 3 consecutive cycles at 0x20,0x24,0x28; READ-back returns 0xA,0xB,0xC.
- len=0 (either dir) → `done` the cycle after `start`, no DRAM or stream activity; `start` during busy ignored.
- READ base=0xFFFF8 len=4 → addresses 0xFFFF8, 0xFFFFC, 0x00000, 0x00004.
- `rst` low mid-READ with FIFO holding 2 words → all outputs 0 immediately; subsequent READ len=2 returns correct fresh data.
